// File: rtl/async_fifo_pkg.sv
// Shared types for the dual-clock FIFO write/read front ends.
// FIFO words are {last, data}; the last flag sits just above the payload.
package async_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } pkt_state_t;

    function automatic int unsigned last_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/wr_skid_buf.sv
// Two-entry skid buffer with a registered in_ready; the out entry feeds the
// consumer, the skid entry catches the one beat accepted while out is stalled.
module wr_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             in_ready_q,   in_ready_d;
    logic             out_valid_q,  out_valid_d;
    logic [WIDTH-1:0] out_data_q,   out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             push;
    logic             pop;

    always_comb begin
        push         = in_valid && in_ready_q;
        pop          = out_valid_q && out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        // in_ready is low whenever skid holds a beat, so push never coincides with it
        if (skid_valid_q) begin
            if (pop) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (out_valid_q && !pop) begin
            if (push) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end else begin
            out_valid_d = push;
            if (push) begin
                out_data_d = in_data;
            end
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/async_fifo_pkt_writer.sv
// Write-side packet front end for the dual-clock FIFO: polices packet length,
// truncates oversize packets with a forced last beat and drops the remainder.
module async_fifo_pkt_writer
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH:0]   fifo_wr_data,
    input  logic                  fifo_full,
    output logic                  err_trunc,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  trunc_cnt
);

    localparam int unsigned LEN_WIDTH = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned LAST_BIT  = last_bit(DATA_WIDTH);
    localparam int unsigned WORD_W    = DATA_WIDTH + 1;

    pkt_state_t            state_q, state_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  err_trunc_q, err_trunc_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_WIDTH-1:0]  trunc_cnt_q, trunc_cnt_d;

    logic                  accept;
    logic                  forward;
    logic                  trunc_beat;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [WORD_W-1:0]     push_data;
    logic                  buf_out_valid;
    logic [WORD_W-1:0]     buf_out_data;

    assign accept = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        forward    = 1'b0;
        trunc_beat = 1'b0;
        beat_idx   = (state_q == PKT) ? beat_q + LEN_WIDTH'(1) : LEN_WIDTH'(1);

        case (state_q)
            IDLE, PKT: begin
                forward    = 1'b1;
                trunc_beat = !s_last && (beat_idx == LEN_WIDTH'(MAX_PKT_LEN));
                if (accept) begin
                    if (s_last) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else if (trunc_beat) begin
                        state_d = DROP;
                        beat_d  = '0;
                    end else begin
                        state_d = PKT;
                        beat_d  = beat_idx;
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase

        push_data   = {s_last || trunc_beat, s_data};
        err_trunc_d = accept && trunc_beat;
        trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(err_trunc_d);
        pkt_cnt_d   = pkt_cnt_q + CNT_WIDTH'(fifo_wr_en && buf_out_data[LAST_BIT]);
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            err_trunc_q <= 1'b0;
            pkt_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            err_trunc_q <= err_trunc_d;
            pkt_cnt_q   <= pkt_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    // Dropped beats still handshake upstream but never enter the buffer
    wr_skid_buf #(
        .WIDTH (WORD_W)
    ) u_skid (
        .clk       (wr_clk),
        .rst_n     (wr_rst_n),
        .in_valid  (s_valid && forward),
        .in_ready  (s_ready),
        .in_data   (push_data),
        .out_valid (buf_out_valid),
        .out_data  (buf_out_data),
        .out_ready (!fifo_full)
    );

    assign fifo_wr_en   = buf_out_valid && !fifo_full;
    assign fifo_wr_data = buf_out_data;
    assign err_trunc    = err_trunc_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign trunc_cnt    = trunc_cnt_q;

endmodule

// File: tb/tb_async_fifo_pkt_writer.sv
// Directed and randomized bench for async_fifo_pkt_writer; expected FIFO words
// are derived per packet from the length-policing rules, independent of beat timing.
module tb_async_fifo_pkt_writer;

    localparam int DW  = 8;
    localparam int MAX = 16;
    localparam int CW  = 16;

    logic          wr_clk;
    logic          wr_rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          fifo_wr_en;
    logic [DW:0]   fifo_wr_data;
    logic          fifo_full;
    logic          err_trunc;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] trunc_cnt;

    async_fifo_pkt_writer #(
        .DATA_WIDTH  (DW),
        .MAX_PKT_LEN (MAX),
        .CNT_WIDTH   (CW)
    ) dut (
        .wr_clk       (wr_clk),
        .wr_rst_n     (wr_rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .err_trunc    (err_trunc),
        .pkt_cnt      (pkt_cnt),
        .trunc_cnt    (trunc_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;

    logic [DW:0] got_q[$];
    int          got_t[$];
    logic [DW:0] exp_q[$];
    int          cmp_idx   = 0;
    int          exp_pkts  = 0;
    int          exp_trunc = 0;
    bit          rand_full = 0;

    int cyc         = 0;
    int acc_cnt     = 0;
    int err_cnt     = 0;
    int err_run     = 0;
    int err_run_max = 0;

    // Observe the write port mid-cycle; each strobe seen here commits at the next edge
    always @(negedge wr_clk) begin
        cyc <= cyc + 1;
        if (fifo_wr_en) begin
            got_q.push_back(fifo_wr_data);
            got_t.push_back(cyc);
        end
        if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
        if (err_trunc) begin
            err_cnt <= err_cnt + 1;
            err_run <= err_run + 1;
            if (err_run + 1 > err_run_max) err_run_max <= err_run + 1;
        end else begin
            err_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
        if (rand_full) fifo_full = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge wr_clk);
        while (!s_ready) begin
            guard++;
            if (guard > 1000) begin
                check("send_ready_timeout", 32'(s_ready), 32'd1);
                break;
            end
            tick();
            @(negedge wr_clk);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Reference: a packet of len beats yields min(len, MAX) words, last set on the final one
    task automatic send_pkt(input int len, input bit rnd, input logic [DW-1:0] start);
        int          n_out;
        logic [DW-1:0] d;
        logic        lst;
        n_out = (len < MAX) ? len : MAX;
        for (int i = 0; i < len; i++) begin
            d = rnd ? DW'($urandom) : start + DW'(i);
            if (i < n_out) begin
                lst = (i == n_out - 1);
                exp_q.push_back({lst, d});
            end
            if (rnd && $urandom_range(0, 3) == 0) tick();
            send_beat(d, i == len - 1);
        end
        exp_pkts++;
        if (len > MAX) exp_trunc++;
        $display("pkt len=%0d words=%0d trunc=%0d total_pkts=%0d", len, n_out, len > MAX, exp_pkts);
    endtask

    task automatic drain();
        int g;
        g = 0;
        rand_full = 0;
        fifo_full = 1'b0;
        while (got_q.size() < exp_q.size() && g < 500) begin
            tick();
            g++;
        end
        repeat (3) tick();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = cmp_idx; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
            if (got_q[i] !== exp_q[i]) break;
        end
        cmp_idx = exp_q.size();
    endtask

    initial begin
        int acc_base;
        int got_base;
        int err_base;
        int idx;

        wr_rst_n  = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_last    = 1'b0;
        fifo_full = 1'b0;

        // Reset and release
        repeat (3) tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        check("rst_err", 32'(err_trunc), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
        wr_rst_n = 1'b1;
        @(negedge wr_clk);
        check("ready_before_edge", 32'(s_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(s_ready), 32'd1);

        // 4-beat packet, back to back
        err_base = err_cnt;
        idx = cmp_idx;
        send_pkt(4, 0, 8'hA0);
        drain();
        compare_stream("pkt4");
        if (got_q.size() >= idx + 4)
            check("pkt4_consecutive", 32'(got_t[idx+3] - got_t[idx]), 32'd3);
        check("pkt4_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        check("pkt4_no_err", 32'(err_cnt - err_base), 32'd0);

        // FIFO full held: only two beats may be taken
        fifo_full = 1'b1;
        tick();
        acc_base = acc_cnt;
        got_base = got_q.size();
        fork
            send_pkt(6, 0, 8'hB0);
        join_none
        repeat (10) tick();
        check("full_accepted", 32'(acc_cnt - acc_base), 32'd2);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_no_write", 32'(got_q.size() - got_base), 32'd0);
        fifo_full = 1'b0;
        wait fork;
        drain();
        compare_stream("full_hold");
        check("full_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

        // Oversize packet then a single-beat packet
        err_base = err_cnt;
        send_pkt(20, 0, 8'h00);
        send_pkt(1, 0, 8'h55);
        drain();
        compare_stream("trunc");
        check("trunc_err_pulses", 32'(err_cnt - err_base), 32'd1);
        check("trunc_err_width", 32'(err_run_max), 32'd1);
        check("trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc));
        check("trunc_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));

        // Randomized packets with random back-pressure
        err_base  = err_cnt;
        rand_full = 1;
        for (int p = 0; p < 1000; p++) begin
            send_pkt(int'($urandom_range(1, 20)), 1, 8'h00);
        end
        drain();
        compare_stream("random");
        check("random_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts & 32'hFFFF));
        check("random_trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc & 32'hFFFF));
        check("random_err_total", 32'(err_cnt - err_base + 1), 32'(exp_trunc));
        check("random_err_width", 32'(err_run_max), 32'd1);

        // Reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 8'hC0 + 8'(i)});
            send_beat(8'hC0 + 8'(i), 1'b0);
        end
        $display("partial pkt beats=3 then reset");
        drain();
        compare_stream("partial");
        #2;
        wr_rst_n = 1'b0;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("midrst_wr_data", 32'(fifo_wr_data), 32'd0);
        check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("midrst_trunc_cnt", 32'(trunc_cnt), 32'd0);
        exp_pkts  = 0;
        exp_trunc = 0;
        repeat (2) tick();
        wr_rst_n = 1'b1;
        send_pkt(4, 0, 8'hD0);
        drain();
        compare_stream("post_rst");
        check("post_rst_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkts));
        check("post_rst_trunc_cnt", 32'(trunc_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
